instr_exec: RTL

Execute stage of the CPU, directly downstream of `instr_fetch`. It takes one decoded instruction at a time from the fetch stage over the `instr_valid`/`ie_ready` handshake. For each instruction it reads a memory operand if one is needed, runs an 8-bit ALU operation, writes the result back to A/X/Y and/or memory, and updates the flags. It then returns the next PC to fetch and pulses `ie_ready` to request the next instruction. It shares the single-port synchronous RAM with fetch, and yields to fetch whenever `accessing_mem` is high.

---
 rtl/instr_exec.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_exec.sv
// Execute stage: accepts one decoded instruction from fetch, optionally reads a
// RAM operand, runs the 8-bit ALU, writes back registers/RAM, and returns the next PC.
module instr_exec #(
    parameter logic [15:0] RESET_PC = 16'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        ie_ready,
    input  logic [7:0]  new_op,
    input  logic [3:0]  alu_op,
    input  logic        imm_mode,
    input  logic        mem_load_flag,
    input  logic [1:0]  reg_load_flag,
    input  logic [2:0]  store_flag,
    input  logic [15:0] if_addr_to_ie,
    input  logic [15:0] pc_to_ie,
    output logic [15:0] pc_from_ie,
    output logic [7:0]  acc_reg,
    output logic [7:0]  x_reg,
    output logic [7:0]  y_reg,
    output logic [3:0]  flags,
    input  logic        accessing_mem,
    output logic [15:0] ie_mem_addr,
    output logic [7:0]  ie_mem_wdata,
    output logic        ie_mem_we,
    input  logic [7:0]  ie_mem_rdata
);

    typedef enum logic [2:0] {
        S_PRIME, S_WAIT_DROP, S_IDLE, S_RD_ADDR, S_RD_WAIT, S_EXEC, S_WR, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  acc_q, acc_d, x_q, x_d, y_q, y_d;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  op_q, op_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        imm_q, imm_d, mem_q, mem_d;
    logic [1:0]  dst_q, dst_d;
    logic [2:0]  st_q, st_d;
    logic [15:0] pcin_q, pcin_d;
    logic [7:0]  opnd_q, opnd_d;

    logic [7:0]  opa_s, opb_s, res_s;
    logic [8:0]  sum_s;
    logic        c_s, v_s;
    logic [3:0]  flags_alu_s;
    logic        pure_store_s, is_store_s;

    // Operand selection from the latched instruction fields.
    always_comb begin
        case (dst_q)
            2'd2:    opa_s = x_q;
            2'd3:    opa_s = y_q;
            default: opa_s = acc_q;
        endcase
        if (mem_q) begin
            opb_s = opnd_q;
        end else if (imm_q) begin
            opb_s = addr_q[7:0];
        end else begin
            opb_s = 8'h00;
        end
    end

    // 8-bit ALU; subtraction is done as A + ~B + carry so carry-out means "no borrow".
    always_comb begin
        sum_s = 9'd0;
        res_s = opb_s;
        c_s   = flags_q[0];
        v_s   = flags_q[2];
        case (alu_op_q)
            4'd1: begin
                sum_s = {1'b0, opa_s} + {1'b0, opb_s} + {8'd0, flags_q[0]};
                res_s = sum_s[7:0];
                c_s   = sum_s[8];
                v_s   = (opa_s[7] == opb_s[7]) && (res_s[7] != opa_s[7]);
            end
            4'd2: begin
                sum_s = {1'b0, opa_s} + {1'b0, ~opb_s} + {8'd0, flags_q[0]};
                res_s = sum_s[7:0];
                c_s   = sum_s[8];
                v_s   = (opa_s[7] != opb_s[7]) && (res_s[7] != opa_s[7]);
            end
            4'd3:  res_s = opa_s & opb_s;
            4'd4:  res_s = opa_s | opb_s;
            4'd5:  res_s = opa_s ^ opb_s;
            4'd6:  res_s = opb_s + 8'd1;
            4'd7:  res_s = opb_s - 8'd1;
            4'd8: begin
                res_s = {opb_s[6:0], 1'b0};
                c_s   = opb_s[7];
            end
            4'd9: begin
                res_s = {1'b0, opb_s[7:1]};
                c_s   = opb_s[0];
            end
            4'd10: begin
                sum_s = {1'b0, opa_s} + {1'b0, ~opb_s} + 9'd1;
                res_s = sum_s[7:0];
                c_s   = sum_s[8];
            end
            default: res_s = opb_s;
        endcase
        flags_alu_s = {res_s[7], v_s, (res_s == 8'h00), c_s};
    end

    assign pure_store_s = (alu_op_q == 4'd0) && (st_q != 3'd0) && (st_q <= 3'd3);
    assign is_store_s   = (st_q != 3'd0) && (st_q <= 3'd4);

    // Next-state and datapath updates for the execute sequence.
    always_comb begin
        state_d  = state_q;
        ready_d  = 1'b0;
        pc_d     = pc_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        flags_d  = flags_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        op_d     = op_q;
        alu_op_d = alu_op_q;
        imm_d    = imm_q;
        mem_d    = mem_q;
        dst_d    = dst_q;
        st_d     = st_q;
        pcin_d   = pcin_q;
        opnd_d   = opnd_q;
        case (state_q)
            S_PRIME: begin
                ready_d = 1'b1;
                state_d = S_WAIT_DROP;
            end
            S_WAIT_DROP: begin
                if (!instr_valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_DROP;
                end
            end
            S_IDLE: begin
                if (instr_valid) begin
                    op_d     = new_op;
                    alu_op_d = alu_op;
                    imm_d    = imm_mode;
                    mem_d    = mem_load_flag;
                    dst_d    = reg_load_flag;
                    st_d     = store_flag;
                    addr_d   = if_addr_to_ie;
                    pcin_d   = pc_to_ie;
                    state_d  = mem_load_flag ? S_RD_ADDR : S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (!accessing_mem) begin
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_RD_ADDR;
                end
            end
            S_RD_WAIT: begin
                opnd_d  = ie_mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (alu_op_q != 4'd10) begin
                    case (dst_q)
                        2'd1:    acc_d = res_s;
                        2'd2:    x_d   = res_s;
                        2'd3:    y_d   = res_s;
                        default: acc_d = acc_q;
                    endcase
                end else begin
                    acc_d = acc_q;
                end
                if (!pure_store_s) begin
                    flags_d = flags_alu_s;
                end else begin
                    flags_d = flags_q;
                end
                // Store data reflects this instruction's own writeback.
                case (st_q)
                    3'd1:    wdata_d = acc_d;
                    3'd2:    wdata_d = x_d;
                    3'd3:    wdata_d = y_d;
                    3'd4:    wdata_d = res_s;
                    default: wdata_d = wdata_q;
                endcase
                state_d = is_store_s ? S_WR : S_DONE;
            end
            S_WR: begin
                if (!accessing_mem) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR;
                end
            end
            S_DONE: begin
                pc_d    = (st_q == 3'd5) ? addr_q : pcin_q;
                ready_d = 1'b1;
                state_d = S_WAIT_DROP;
            end
            default: state_d = S_PRIME;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_PRIME;
            ready_q  <= 1'b0;
            pc_q     <= RESET_PC;
            acc_q    <= 8'h00;
            x_q      <= 8'h00;
            y_q      <= 8'h00;
            flags_q  <= 4'h0;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            op_q     <= 8'h00;
            alu_op_q <= 4'h0;
            imm_q    <= 1'b0;
            mem_q    <= 1'b0;
            dst_q    <= 2'd0;
            st_q     <= 3'd0;
            pcin_q   <= 16'h0000;
            opnd_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            flags_q  <= flags_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            op_q     <= op_d;
            alu_op_q <= alu_op_d;
            imm_q    <= imm_d;
            mem_q    <= mem_d;
            dst_q    <= dst_d;
            st_q     <= st_d;
            pcin_q   <= pcin_d;
            opnd_q   <= opnd_d;
        end
    end

    // The write strobe must drop in the same cycle fetch claims the RAM.
    assign ie_mem_we    = (state_q == S_WR) && !accessing_mem;
    assign ie_ready     = ready_q;
    assign pc_from_ie   = pc_q;
    assign acc_reg      = acc_q;
    assign x_reg        = x_q;
    assign y_reg        = y_q;
    assign flags        = flags_q;
    assign ie_mem_addr  = addr_q;
    assign ie_mem_wdata = wdata_q;

endmodule
